uart_tx_ctrl: RTL and testbench

- Frame sequencer for the UART transmit path.
- Accepts a parallel word handshake and drives the external serializer's ser_en. Reads back ser_data and ser_done from it.
- Computes parity and multiplexes start, data, parity and stop bits onto a glitch-free registered tx_out line.
- Drives the busy signal back to the serializer and the upstream source. The serializer loads p_data only when data_valid is high and busy is low.

---
 rtl/uart_tx_ctrl_if.sv | 28 ++
 rtl/uart_tx_ctrl.sv | 118 +++++++++++
 tb/tb_uart_tx_ctrl.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_ctrl_if.sv
// Purpose: handshake/bus bundle between the UART frame sequencer, its upstream
//          word source and the external serializer.
// Ports:   master = upstream + serializer side, slave = uart_tx_ctrl.
interface uart_tx_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  data_valid;  // upstream word available
  logic [DATA_WIDTH-1:0] p_data;      // parallel word (parity source only)
  logic                  par_en;      // 1 = insert parity bit
  logic                  par_type;    // 0 = even, 1 = odd
  logic                  ser_data;    // serializer current LSB
  logic                  ser_done;    // serializer last-bit indication
  logic                  ser_en;      // serializer shift/count enable
  logic                  busy;        // frame in progress
  logic                  tx_out;      // serial line, idle high
  logic                  tx_done;     // one-cycle end-of-frame pulse
  logic                  sync_err;    // sticky serializer desync flag

  modport master (
    output data_valid, p_data, par_en, par_type, ser_data, ser_done,
    input  ser_en, busy, tx_out, tx_done, sync_err
  );

  modport slave (
    input  data_valid, p_data, par_en, par_type, ser_data, ser_done,
    output ser_en, busy, tx_out, tx_done, sync_err
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// Purpose: UART transmit frame sequencer; muxes start/data/parity/stop onto a
//          registered tx_out and paces the external serializer via ser_en.
// Latency: word accepted in IDLE, start bit on tx_out two cycles later; every
//          bit lasts one clk; tx_out lags the state by one cycle.
// Backpressure: busy=1 outside IDLE; data_valid is ignored until IDLE returns.
// Ports:   clk, rst (async active-low), bus (uart_tx_ctrl_if.slave).
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_ctrl_if.slave bus
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic             par_en_q;
  logic             par_type_q;
  logic             parity_q;
  logic             busy_q;
  logic             ser_en_q;
  logic             tx_out_q;
  logic             tx_done_q;
  logic             sync_err_q;
  logic             last_bit;

  assign last_bit = (bit_cnt == LAST_BIT);

  // busy/ser_en/tx_done are loaded from the next state so that, as registers,
  // they always equal a decode of the current state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      par_en_q   <= 1'b0;
      par_type_q <= 1'b0;
      parity_q   <= 1'b0;
      busy_q     <= 1'b0;
      ser_en_q   <= 1'b0;
      tx_out_q   <= 1'b1;
      tx_done_q  <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      case (state)
        IDLE: begin
          tx_out_q <= 1'b1;
          if (bus.data_valid) begin
            // The serializer loads p_data on this same edge (busy is low).
            par_en_q   <= bus.par_en;
            par_type_q <= bus.par_type;
            parity_q   <= (^bus.p_data) ^ bus.par_type;
            state      <= START;
            busy_q     <= 1'b1;
          end
        end
        START: begin
          tx_out_q <= 1'b0;
          bit_cnt  <= '0;
          state    <= DATA;
          ser_en_q <= 1'b1;
        end
        DATA: begin
          tx_out_q <= bus.ser_data;
          bit_cnt  <= bit_cnt + 1'b1;
          // Leave on whichever of ser_done / own count comes first; any
          // disagreement between them means the serializer lost step.
          if (bus.ser_done || last_bit) begin
            if (bus.ser_done != last_bit) begin
              sync_err_q <= 1'b1;
            end
            ser_en_q <= 1'b0;
            if (par_en_q) begin
              state <= PARITY;
            end else begin
              state     <= STOP;
              tx_done_q <= 1'b1;
            end
          end
        end
        PARITY: begin
          tx_out_q  <= parity_q;
          state     <= STOP;
          tx_done_q <= 1'b1;
        end
        STOP: begin
          tx_out_q <= 1'b1;
          state    <= IDLE;
          busy_q   <= 1'b0;
        end
        default: begin
          tx_out_q <= 1'b1;
          state    <= IDLE;
          busy_q   <= 1'b0;
          ser_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.ser_en   = ser_en_q;
  assign bus.tx_out   = tx_out_q;
  assign bus.tx_done  = tx_done_q;
  assign bus.sync_err = sync_err_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Purpose: self-checking bench for uart_tx_ctrl with a behavioural serializer.
// Ports:   none (top level); drives uart_tx_ctrl_if as master.
module tb_uart_tx_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  uart_tx_ctrl_if #(.DATA_WIDTH(8)) bus ();

  uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Behavioural serializer: loads on data_valid & !busy, shifts on ser_en.
  logic [7:0] sr;
  logic [2:0] scnt;
  logic       early_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr   <= 8'h00;
      scnt <= 3'd0;
    end else if (bus.data_valid && !bus.busy) begin
      sr   <= bus.p_data;
      scnt <= 3'd0;
    end else if (bus.ser_en) begin
      sr   <= sr >> 1;
      scnt <= scnt + 3'd1;
    end
  end

  assign bus.ser_data = sr[0];
  assign bus.ser_done = bus.ser_en && (early_done ? (scnt == 3'd4) : (scnt == 3'd7));

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", nm, act, exp);
    end
  endtask

  // Bit k of each mask is the expected value in cycle T+k (T = accept cycle).
  typedef struct {
    logic [7:0]  p_data;
    logic        par_en;
    logic        par_type;
    logic [13:0] exp_tx;
    logic [13:0] exp_busy;
    logic [13:0] exp_ser_en;
    logic [13:0] exp_done;
  } vec_t;

  vec_t vecs[6];

  task automatic sample(input int v, input int k, input vec_t e);
    chk($sformatf("v%0d_k%0d_tx_out", v, k), bus.tx_out, e.exp_tx[k]);
    chk($sformatf("v%0d_k%0d_busy", v, k), bus.busy, e.exp_busy[k]);
    chk($sformatf("v%0d_k%0d_ser_en", v, k), bus.ser_en, e.exp_ser_en[k]);
    chk($sformatf("v%0d_k%0d_tx_done", v, k), bus.tx_done, e.exp_done[k]);
    chk($sformatf("v%0d_k%0d_sync_err", v, k), bus.sync_err, 1'b0);
  endtask

  logic [24:0] cap_busy, cap_tx, cap_done, cap_sen, cap_serr;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 14'b11_0101_0010_1011, 14'h0FFE, 14'h03FC, 14'h0800};
    vecs[1] = '{8'hA5, 1'b1, 1'b1, 14'b11_1101_0010_1011, 14'h0FFE, 14'h03FC, 14'h0800};
    vecs[2] = '{8'hA5, 1'b0, 1'b0, 14'b11_1101_0010_1011, 14'h07FE, 14'h03FC, 14'h0400};
    vecs[3] = '{8'h3C, 1'b1, 1'b1, 14'b11_1001_1110_0011, 14'h0FFE, 14'h03FC, 14'h0800};
    vecs[4] = '{8'h01, 1'b1, 1'b0, 14'b11_1000_0000_1011, 14'h0FFE, 14'h03FC, 14'h0800};
    vecs[5] = '{8'h80, 1'b0, 1'b1, 14'b11_1100_0000_0011, 14'h07FE, 14'h03FC, 14'h0400};

    bus.data_valid = 1'b0;
    bus.p_data     = 8'h00;
    bus.par_en     = 1'b0;
    bus.par_type   = 1'b0;
    early_done     = 1'b0;

    // Reset state, then idle for 5 cycles.
    repeat (2) @(negedge clk);
    chk("rst_tx_out", bus.tx_out, 1'b1);
    chk("rst_busy", bus.busy, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("idle%0d_tx_out", i), bus.tx_out, 1'b1);
      chk($sformatf("idle%0d_busy", i), bus.busy, 1'b0);
      chk($sformatf("idle%0d_ser_en", i), bus.ser_en, 1'b0);
      chk($sformatf("idle%0d_tx_done", i), bus.tx_done, 1'b0);
      chk($sformatf("idle%0d_sync_err", i), bus.sync_err, 1'b0);
    end

    // Table-driven single frames; inputs are scrambled right after accept.
    for (int v = 0; v < 6; v++) begin
      @(posedge clk); #1;
      bus.data_valid = 1'b1;
      bus.p_data     = vecs[v].p_data;
      bus.par_en     = vecs[v].par_en;
      bus.par_type   = vecs[v].par_type;
      @(negedge clk);
      sample(v, 0, vecs[v]);
      @(posedge clk); #1;
      bus.data_valid = 1'b0;
      bus.p_data     = ~bus.p_data;
      bus.par_en     = ~bus.par_en;
      bus.par_type   = ~bus.par_type;
      for (int k = 1; k < 14; k++) begin
        @(negedge clk);
        sample(v, k, vecs[v]);
      end
    end

    // Back-to-back: data_valid held high, 0x00 then 0xFF, even parity.
    @(posedge clk); #1;
    bus.data_valid = 1'b1;
    bus.p_data     = 8'h00;
    bus.par_en     = 1'b1;
    bus.par_type   = 1'b0;
    @(negedge clk);
    chk("b2b_k0_busy", bus.busy, 1'b0);
    @(posedge clk); #1;
    bus.p_data = 8'hFF;
    for (int k = 1; k < 25; k++) begin
      @(negedge clk);
      cap_busy[k] = bus.busy;
      cap_tx[k]   = bus.tx_out;
      cap_done[k] = bus.tx_done;
      if (k == 12) begin
        @(posedge clk); #1;
        bus.data_valid = 1'b0;
      end
    end
    chk("b2b_k1_busy", cap_busy[1], 1'b1);
    chk("b2b_k11_busy", cap_busy[11], 1'b1);
    chk("b2b_k12_busy_stop_ignored", cap_busy[12], 1'b0);
    chk("b2b_k13_busy_second_start", cap_busy[13], 1'b1);
    chk("b2b_k23_busy", cap_busy[23], 1'b1);
    chk("b2b_k24_busy", cap_busy[24], 1'b0);
    chk("b2b_k11_done", cap_done[11], 1'b1);
    chk("b2b_k12_done", cap_done[12], 1'b0);
    chk("b2b_k23_done", cap_done[23], 1'b1);
    chk("b2b_k2_start", cap_tx[2], 1'b0);
    chk("b2b_k3_data0", cap_tx[3], 1'b0);
    chk("b2b_k11_parity0", cap_tx[11], 1'b0);
    chk("b2b_k12_stop", cap_tx[12], 1'b1);
    chk("b2b_k14_start", cap_tx[14], 1'b0);
    chk("b2b_k15_data1", cap_tx[15], 1'b1);
    chk("b2b_k22_data1", cap_tx[22], 1'b1);
    chk("b2b_k23_parity1", cap_tx[23], 1'b0);
    chk("b2b_k24_stop", cap_tx[24], 1'b1);

    // Early ser_done on the 5th DATA cycle (T+6).
    repeat (2) @(negedge clk);
    early_done = 1'b1;
    @(posedge clk); #1;
    bus.data_valid = 1'b1;
    bus.p_data     = 8'hA5;
    bus.par_en     = 1'b1;
    bus.par_type   = 1'b0;
    @(posedge clk); #1;
    bus.data_valid = 1'b0;
    for (int k = 1; k < 13; k++) begin
      @(negedge clk);
      cap_busy[k] = bus.busy;
      cap_tx[k]   = bus.tx_out;
      cap_done[k] = bus.tx_done;
      cap_sen[k]  = bus.ser_en;
      cap_serr[k] = bus.sync_err;
    end
    early_done = 1'b0;
    chk("sync_k5_err_low", cap_serr[5], 1'b0);
    chk("sync_k6_ser_en", cap_sen[6], 1'b1);
    chk("sync_k7_err_high", cap_serr[7], 1'b1);
    chk("sync_k7_ser_en_off", cap_sen[7], 1'b0);
    chk("sync_k8_parity_bit", cap_tx[8], 1'b0);
    chk("sync_k8_busy", cap_busy[8], 1'b1);
    chk("sync_k8_done", cap_done[8], 1'b1);
    chk("sync_k9_stop_bit", cap_tx[9], 1'b1);
    chk("sync_k9_idle", cap_busy[9], 1'b0);
    chk("sync_k12_sticky", cap_serr[12], 1'b1);

    // Reset in the 4th DATA cycle (T+5) of a 0x00 frame.
    @(posedge clk); #1;
    bus.data_valid = 1'b1;
    bus.p_data     = 8'h00;
    bus.par_en     = 1'b1;
    bus.par_type   = 1'b0;
    @(posedge clk); #1;
    bus.data_valid = 1'b0;
    for (int k = 1; k < 6; k++) @(negedge clk);
    chk("rstmid_pre_tx_out", bus.tx_out, 1'b0);
    chk("rstmid_pre_ser_en", bus.ser_en, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("rstmid_tx_out", bus.tx_out, 1'b1);
    chk("rstmid_busy", bus.busy, 1'b0);
    chk("rstmid_ser_en", bus.ser_en, 1'b0);
    chk("rstmid_tx_done", bus.tx_done, 1'b0);
    chk("rstmid_sync_err", bus.sync_err, 1'b0);
    repeat (2) @(negedge clk);
    chk("rstmid_hold_tx_done", bus.tx_done, 1'b0);
    rst = 1'b1;

    // Clean frame after reset release: 0x5A without parity.
    @(posedge clk); #1;
    bus.data_valid = 1'b1;
    bus.p_data     = 8'h5A;
    bus.par_en     = 1'b0;
    @(negedge clk);
    chk("post_k0_busy", bus.busy, 1'b0);
    @(posedge clk); #1;
    bus.data_valid = 1'b0;
    for (int k = 1; k < 12; k++) begin
      @(negedge clk);
      cap_busy[k] = bus.busy;
      cap_tx[k]   = bus.tx_out;
      cap_done[k] = bus.tx_done;
    end
    chk("post_k1_busy", cap_busy[1], 1'b1);
    chk("post_k2_start", cap_tx[2], 1'b0);
    chk("post_k3_bit0", cap_tx[3], 1'b0);
    chk("post_k4_bit1", cap_tx[4], 1'b1);
    chk("post_k10_done", cap_done[10], 1'b1);
    chk("post_k11_stop", cap_tx[11], 1'b1);
    chk("post_k11_idle", cap_busy[11], 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
